// File: rtl/axi_lite_sram_if.sv
// Purpose: AXI4-Lite bundle (AW/W/B/AR/R channels) between a master and the SRAM slave.
// Latency: none, wires only.
// Backpressure: carried by the per-channel VALID/READY pairs.
interface axi_lite_sram_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 64
);
    localparam int DSIZE = DWIDTH / 8;

    logic [AWIDTH-1:0] AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [DWIDTH-1:0] WDATA;
    logic [DSIZE-1:0]  WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic              BVALID;
    logic [1:0]        BRESP;
    logic              BREADY;
    logic [AWIDTH-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [DWIDTH-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi_lite_sram.sv
// Purpose: AXI4-Lite slave backed by on-chip dual-port storage, decoded window, SLVERR outside it.
// Latency: write commits 1 edge after AW+W are both held; read data RD_LATENCY edges after AR.
// Backpressure: one outstanding B and one outstanding R; held B blocks the next commit, held R blocks AR.
module axi_lite_sram #(
    parameter int                AWIDTH     = 32,
    parameter int                DWIDTH     = 64,
    parameter int                DSIZE      = DWIDTH / 8,
    parameter int                DEPTH_LOG2 = 12,
    parameter logic [AWIDTH-1:0] BASE_ADDR  = AWIDTH'(32'h8000_0000),
    parameter int                RD_LATENCY = 1
) (
    input  logic             clk,
    input  logic             resetn,
    axi_lite_sram_if.slave   bus
);
    localparam int         SHIFT    = $clog2(DSIZE);
    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [1:0] OKAY     = 2'b00;
    localparam logic [1:0] SLVERR   = 2'b10;
    localparam logic [1:0] CNT_LOAD = 2'(RD_LATENCY - 1);

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;

    // Unaligned low address bits are simply dropped by the index shift.
    function automatic logic in_win(input logic [AWIDTH-1:0] a);
        logic [AWIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ((off >> (SHIFT + DEPTH_LOG2)) == '0);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] idx_of(input logic [AWIDTH-1:0] a);
        logic [AWIDTH-1:0] off;
        off = a - BASE_ADDR;
        return DEPTH_LOG2'(off >> SHIFT);
    endfunction

    logic [DWIDTH-1:0] mem [DEPTH];

    logic              aw_full;
    logic [AWIDTH-1:0] aw_addr;
    logic              w_full;
    logic [DWIDTH-1:0] w_data;
    logic [DSIZE-1:0]  w_strb;
    logic              bvalid;
    logic [1:0]        bresp;
    logic              commit;

    rd_state_t         rd_state;
    logic [1:0]        rd_cnt;
    logic [AWIDTH-1:0] ar_addr;
    logic [DWIDTH-1:0] rdata;
    logic [1:0]        rresp;

    // Commit only when both halves are present and the single B slot is free.
    assign commit = aw_full & w_full & ~bvalid;

    assign bus.AWREADY = ~aw_full;
    assign bus.WREADY  = ~w_full;
    assign bus.BVALID  = bvalid;
    assign bus.BRESP   = bresp;
    assign bus.ARREADY = (rd_state == RD_IDLE);
    assign bus.RVALID  = (rd_state == RD_RESP);
    assign bus.RDATA   = rdata;
    assign bus.RRESP   = rresp;

    // AW/W holding registers fill independently and drain together on commit; B slot follows.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            aw_full <= 1'b0;
            aw_addr <= '0;
            w_full  <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
        end else begin
            if (bus.AWVALID && !aw_full) begin
                aw_full <= 1'b1;
                aw_addr <= bus.AWADDR;
            end
            if (bus.WVALID && !w_full) begin
                w_full <= 1'b1;
                w_data <= bus.WDATA;
                w_strb <= bus.WSTRB;
            end
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= in_win(aw_addr) ? OKAY : SLVERR;
            end else if (bvalid && bus.BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Storage is never reset; byte lanes are written only under their strobe.
    always_ff @(posedge clk) begin
        if (commit && in_win(aw_addr)) begin
            for (int i = 0; i < DSIZE; i++) begin
                if (w_strb[i]) begin
                    mem[idx_of(aw_addr)][8*i +: 8] <= w_data[8*i +: 8];
                end
            end
        end
    end

    // Read FSM: idle -> latency countdown -> response held until RREADY.
    // A same-edge write is not visible here because both sides use non-blocking updates.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            rd_state <= RD_IDLE;
            rd_cnt   <= '0;
            ar_addr  <= '0;
            rdata    <= '0;
            rresp    <= OKAY;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (bus.ARVALID) begin
                        ar_addr  <= bus.ARADDR;
                        rd_cnt   <= CNT_LOAD;
                        rd_state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (rd_cnt == 2'd0) begin
                        rd_state <= RD_RESP;
                        if (in_win(ar_addr)) begin
                            rdata <= mem[idx_of(ar_addr)];
                            rresp <= OKAY;
                        end else begin
                            rdata <= '0;
                            rresp <= SLVERR;
                        end
                    end else begin
                        rd_cnt <= rd_cnt - 2'd1;
                    end
                end
                RD_RESP: begin
                    if (bus.RREADY) begin
                        rd_state <= RD_IDLE;
                        rdata    <= '0;
                        rresp    <= OKAY;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end
endmodule

// File: doc/axi_lite_sram.md
Name: axi_lite_sram

Overview:
Parametrised AXI4-Lite slave memory with on-chip storage instead of DPI-C backing, for NPC peripheral and memory-subsystem simulation and synthesis. It supports independent AW/W arrival order, byte strobes, configurable read latency and a decoded address window with SLVERR outside it. Full B/R backpressure is supported. It is the drop-in successor slave behind the core's LSU/IFU AXI-Lite masters.

Parameters:
AWIDTH, 32, address width
DWIDTH, 64, data width; 32 or 64 only
DSIZE, DWIDTH/8, strobe width in bytes
DEPTH_LOG2, 12, log2 of memory depth in DWIDTH words
BASE_ADDR, 32'h8000_0000, first byte address of the window
RD_LATENCY, 1, cycles from AR handshake to RVALID; legal 1..4

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous, active-high reset
AWADDR  in  AWIDTH  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DWIDTH  write data
WSTRB  in  DSIZE  byte enables
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BVALID  out  1  write response valid
BRESP  out  2  00 OKAY, 10 SLVERR
BREADY  in  1  write response ready
ARADDR  in  AWIDTH  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  DWIDTH  read data
RRESP  out  2  00 OKAY, 10 SLVERR
RVALID  out  1  read data valid
RREADY  in  1  read data ready

Behaviour:
- Reset (asynchronous, while resetn=1): AWREADY=WREADY=ARREADY=1, BVALID=RVALID=0, BRESP=RRESP=00, RDATA=0. All pending AW/W/read state is dropped; no B/R is issued for it. Memory contents are not cleared (zero only at simulation start).
- Decode: index = (addr-BASE_ADDR)>>log2(DSIZE). An address is in range iff addr>=BASE_ADDR and index<2^DEPTH_LOG2. Low log2(DSIZE) address bits are ignored, so unaligned addresses are treated as aligned.
- Write side: separate one-entry holding registers for AW (addr) and W (data, strobe).
  - AWREADY = AW holder empty. WREADY = W holder empty. Both are registered.
  - AW and W may handshake in either order, or in the same cycle.
  - Commit cycle: both holders full and BVALID=0. At that edge:
    - bytes with WSTRB[i]=1 are written; WSTRB=0 writes nothing but still responds OKAY;
    - BVALID<=1 and BRESP<=00, or 10 if out of range (no memory write);
    - both holders clear, so AWREADY=WREADY=1 the next cycle.
  - Minimum latency: AW+W handshake at edge 0, commit at edge 1, BVALID high after edge 1.
  - BVALID/BRESP hold until BREADY. The B handshake clears BVALID. A pending commit waits while BVALID=1, so only one outstanding write response exists.
- Read side: one outstanding read.
  - ARREADY=1 only when idle, i.e. no read in the latency pipe and RVALID=0.
  - AR handshake at edge 0 latches the address and drops ARREADY. A down-counter loads RD_LATENCY-1.
  - At edge RD_LATENCY the memory is sampled into RDATA, RRESP is set, and RVALID<=1. Out-of-range gives RDATA=0, RRESP=10.
  - RDATA/RRESP are stable while RVALID=1 and RREADY=0.
  - The R handshake clears RVALID, and ARREADY=1 the following cycle.
- Read/write collision: read and write ports are independent (dual-port). If a write commits on the same edge the read samples memory at the same index, the read returns old data. Later reads return new data.
- Simultaneous AR and AW/W handshakes in one cycle are legal and fully independent.
- RDATA is 0 outside a valid response; its value while RVALID=0 is don't-care for masters.

Test Plan:
- Reset, then AW=0x8000_0008 and W=0x1122334455667788 with WSTRB=0xFF in the same cycle, BREADY=1 -> BVALID after 2 edges, BRESP=00. Read of 0x8000_0008 with RD_LATENCY=1 -> RVALID 1 edge after AR, RDATA=0x1122334455667788, RRESP=00.
- W first (WSTRB=0x0F, data 0xAAAAAAAA_BBBBBBBB) 3 cycles before AW=0x8000_0008 -> WREADY low until commit. Readback=0x11223344_BBBBBBBB.
- Write to 0x7FFF_FFF8 and read 0x8000_0000+8*2^DEPTH_LOG2 -> BRESP=10, RRESP=10, RDATA=0, memory unchanged.
- RD_LATENCY=3, RREADY held 0 for 5 cycles -> RVALID 3 edges after AR, RDATA/RRESP stable, ARREADY=0 until 1 cycle after the R handshake.
- BREADY=0 with a second AW/W pair accepted -> no second commit until the first B handshake. The second BVALID rises 1 edge after it.
- resetn pulsed asynchronously mid-read (counter=1) and with AW held -> outputs return immediately to reset values, no RVALID/BVALID afterwards, earlier committed data intact.
